// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one item, waits for the data-memory
// response owed by a load/store, aligns load data and hands the item to writeback.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  output logic        mem_allow_in,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_signed,
  input  logic        in_is_load,
  input  logic        in_mem_req,
  input  logic [4:0]  in_dest,
  input  logic        in_gr_we,
  input  logic        in_ex,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allow_in,
  input  logic        flush,
  output logic        mem_to_wb_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_gr_we,
  output logic        out_ex,
  output logic        mem_ex,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_block
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        valid;
  logic [31:0] pc, alu;
  logic [1:0]  ld_size;
  logic        ld_signed, is_load, mem_req, gr_we, ex;
  logic [4:0]  dest;
  logic [31:0] rbuf;
  logic        data_avail, ready_go, accept, capture, new_req;
  logic [31:0] load_src, load_data;

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] addr,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // handshake and datapath decode
  always_comb begin
    data_avail   = ((state == ST_WAIT) && data_sram_data_ok) || (state == ST_HOLD);
    ready_go     = ~valid || ~mem_req || data_avail;
    mem_allow_in = (state != ST_DROP) && (~valid || (ready_go && wb_allow_in));
    accept       = ex_to_mem_valid && mem_allow_in && ~flush;
    new_req      = accept && in_mem_req;
    capture      = (state == ST_WAIT) && data_sram_data_ok && ~wb_allow_in && ~flush;
    load_src     = (state == ST_HOLD) ? rbuf : data_sram_rdata;
    load_data    = extract_load(load_src, alu[1:0], ld_size, ld_signed);
  end

  // response tracking next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (new_req) state_next = ST_WAIT;
        else         state_next = ST_IDLE;
      end
      ST_WAIT: begin
        // a response arriving alongside the flush settles the debt
        if (flush)                  state_next = data_sram_data_ok ? ST_IDLE : ST_DROP;
        else if (!data_sram_data_ok) state_next = ST_WAIT;
        else if (!wb_allow_in)       state_next = ST_HOLD;
        else if (new_req)            state_next = ST_WAIT;
        else                         state_next = ST_IDLE;
      end
      ST_HOLD: begin
        if (flush)             state_next = ST_IDLE;
        else if (!wb_allow_in) state_next = ST_HOLD;
        else if (new_req)      state_next = ST_WAIT;
        else                   state_next = ST_IDLE;
      end
      ST_DROP: begin
        if (data_sram_data_ok) state_next = ST_IDLE;
        else                   state_next = ST_DROP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // item valid bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           valid <= 1'b0;
    else if (flush)        valid <= 1'b0;
    else if (mem_allow_in) valid <= ex_to_mem_valid;
  end

  // item payload registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= 32'd0;
      alu       <= 32'd0;
      ld_size   <= 2'd0;
      ld_signed <= 1'b0;
      is_load   <= 1'b0;
      mem_req   <= 1'b0;
      dest      <= 5'd0;
      gr_we     <= 1'b0;
      ex        <= 1'b0;
    end else if (accept) begin
      pc        <= in_pc;
      alu       <= in_alu_result;
      ld_size   <= in_ld_size;
      ld_signed <= in_ld_signed;
      is_load   <= in_is_load;
      mem_req   <= in_mem_req;
      dest      <= in_dest;
      gr_we     <= in_gr_we;
      ex        <= in_ex;
    end
  end

  // response buffer for when writeback stalls on the data_ok cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      rbuf <= 32'd0;
    else if (capture) rbuf <= data_sram_rdata;
  end

  // output decode
  always_comb begin
    mem_to_wb_valid = valid && ready_go;
    out_pc          = pc;
    out_result      = is_load ? load_data : alu;
    out_dest        = dest;
    out_gr_we       = gr_we;
    out_ex          = ex;
    mem_ex          = valid && ex;
    fwd_dest        = (valid && gr_we) ? dest : 5'd0;
    fwd_data        = out_result;
    fwd_block       = valid && is_load && ~data_avail;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized traffic against a queue-based reference,
// followed by directed scenarios for hold, flush/drop, back-to-back and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_to_mem_valid, mem_allow_in;
  logic [31:0] in_pc, in_alu_result;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed, in_is_load, in_mem_req, in_gr_we, in_ex;
  logic [4:0]  in_dest;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in, flush;
  logic        mem_to_wb_valid;
  logic [31:0] out_pc, out_result, fwd_data;
  logic [4:0]  out_dest, fwd_dest;
  logic        out_gr_we, out_ex, mem_ex, fwd_block;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(mem_allow_in),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_ld_size(in_ld_size),
    .in_ld_signed(in_ld_signed), .in_is_load(in_is_load), .in_mem_req(in_mem_req),
    .in_dest(in_dest), .in_gr_we(in_gr_we), .in_ex(in_ex),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allow_in(wb_allow_in), .flush(flush),
    .mem_to_wb_valid(mem_to_wb_valid), .out_pc(out_pc), .out_result(out_result),
    .out_dest(out_dest), .out_gr_we(out_gr_we), .out_ex(out_ex), .mem_ex(mem_ex),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_block(fwd_block)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        we;
    logic        ex;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] resp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          cap_en = 1'b0;
  bit          mon_en = 1'b0;
  bit          acc_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
      if (sg && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
      if (sg && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_to_mem_valid   = 1'b0;
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
    wb_allow_in       = 1'b1;
  endtask

  task automatic set_item(input logic [31:0] pc, input logic [31:0] alu, input logic [1:0] sz,
                          input logic sg, input logic ld, input logic req, input logic [4:0] d,
                          input logic we, input logic exf);
    ex_to_mem_valid = 1'b1;
    in_pc = pc; in_alu_result = alu; in_ld_size = sz; in_ld_signed = sg;
    in_is_load = ld; in_mem_req = req; in_dest = d; in_gr_we = we; in_ex = exf;
  endtask

  // accept capture: records the expected result and the response the memory will return
  initial begin
    exp_t        e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      acc_seen = 1'b0;
      if (cap_en && resetn && ex_to_mem_valid && mem_allow_in && !flush) begin
        acc_seen = 1'b1;
        r = 32'd0;
        if (in_mem_req) begin
          r = $urandom;
          resp_q.push_back(r);
        end
        e.pc     = in_pc;
        e.result = in_is_load ? ref_load(r, in_alu_result, in_ld_size, in_ld_signed) : in_alu_result;
        e.dest   = in_dest;
        e.we     = in_gr_we;
        e.ex     = in_ex;
        sb.push_back(e);
      end
    end
  end

  // monitor: compares every item handed to writeback
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && mem_to_wb_valid && wb_allow_in) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: got item pc %h, expected no item", out_pc);
        end else begin
          e = sb.pop_front();
          check("rnd_pc", out_pc, e.pc);
          check("rnd_result", out_result, e.result);
          check("rnd_fwd_data", fwd_data, e.result);
          check("rnd_dest", {27'd0, out_dest}, {27'd0, e.dest});
          check("rnd_gr_we", {31'd0, out_gr_we}, {31'd0, e.we});
          check("rnd_mem_ex", {31'd0, mem_ex}, {31'd0, e.ex});
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    set_item(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_to_mem_valid = 1'b0;
    data_sram_rdata = 32'd0;
    #3;
    check("rst_allow", {31'd0, mem_allow_in}, 32'd1);
    check("rst_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_fwd", {26'd0, fwd_block, fwd_dest}, 32'd0);
    step(); step();
    resetn = 1'b1;

    // randomized traffic, no flush
    cap_en = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (!ex_to_mem_valid || acc_seen) begin
        in_is_load    = ($urandom_range(0, 1) == 0);
        in_mem_req    = in_is_load || ($urandom_range(0, 2) == 0);
        in_ld_size    = 2'($urandom_range(0, 2));
        in_ld_signed  = 1'($urandom_range(0, 1));
        in_pc         = $urandom;
        in_alu_result = $urandom;
        in_dest       = 5'($urandom_range(0, 31));
        in_gr_we      = 1'($urandom_range(0, 1));
        in_ex         = ($urandom_range(0, 7) == 0);
        ex_to_mem_valid = ($urandom_range(0, 3) != 0);
      end
      wb_allow_in       = ($urandom_range(0, 3) != 0);
      data_sram_rdata   = $urandom;
      data_sram_data_ok = 1'b0;
      if (resp_q.size() > 0) begin
        if ($urandom_range(0, 2) == 0) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata   = resp_q.pop_front();
        end
      end else if ($urandom_range(0, 7) == 0) begin
        data_sram_data_ok = 1'b1;
      end
    end
    for (int c = 0; c < 20; c++) begin
      step();
      ex_to_mem_valid   = 1'b0;
      wb_allow_in       = 1'b1;
      data_sram_data_ok = 1'b0;
      if (resp_q.size() > 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = resp_q.pop_front();
      end
    end
    @(negedge clk);
    check("drain_sb_empty", sb.size(), 32'd0);
    cap_en = 1'b0;
    mon_en = 1'b0;

    // signed byte load, response two cycles after accept
    step(); idle_inputs();
    set_item(32'h0000_1000, 32'h0000_2003, 2'b00, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    @(negedge clk); check("b_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); ex_to_mem_valid = 1'b0;
    @(negedge clk); check("b_wait_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    check("b_wait_block", {31'd0, fwd_block}, 32'd1);
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234;
    @(negedge clk); check("b_ok_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    check("b_result", out_result, 32'hFFFF_FF80);
    check("b_ok_block", {31'd0, fwd_block}, 32'd0);
    step(); data_sram_data_ok = 1'b0;
    @(negedge clk); check("b_after_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // unsigned half load held while writeback stalls
    step();
    set_item(32'h0000_1004, 32'h0000_2002, 2'b01, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    step(); ex_to_mem_valid = 1'b0; data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8765_4321; wb_allow_in = 1'b0;
    @(negedge clk); check("h_ok_result", out_result, 32'h0000_8765);
    check("h_ok_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; wb_allow_in = 1'b0;
      @(negedge clk); check("h_hold_result", out_result, 32'h0000_8765);
      check("h_hold_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      check("h_hold_allow", {31'd0, mem_allow_in}, 32'd0);
    end
    step(); wb_allow_in = 1'b1;
    @(negedge clk); check("h_rel_result", out_result, 32'h0000_8765);
    check("h_rel_allow", {31'd0, mem_allow_in}, 32'd1);
    step();
    @(negedge clk); check("h_after_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // non-memory ALU items, second carries an exception and no write
    step();
    set_item(32'h0000_1008, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    set_item(32'h0000_100C, 32'hCAFE_0000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1);
    @(negedge clk); check("a_result", out_result, 32'h1234_5678);
    check("a_fwd_dest", {27'd0, fwd_dest}, 32'd5);
    check("a_fwd_block", {31'd0, fwd_block}, 32'd0);
    check("a_fwd_data", fwd_data, 32'h1234_5678);
    check("a_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    step(); ex_to_mem_valid = 1'b0;
    @(negedge clk); check("a2_pc", out_pc, 32'h0000_100C);
    check("a2_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    check("a2_mem_ex", {31'd0, mem_ex}, 32'd1);
    step();
    @(negedge clk); check("a3_mem_ex", {31'd0, mem_ex}, 32'd0);

    // flush while waiting: next response dropped, new load gets its own data
    step();
    set_item(32'h0000_1010, 32'h0000_3000, 2'b10, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step(); ex_to_mem_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    set_item(32'h0000_1014, 32'h0000_3004, 2'b10, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    @(negedge clk); check("f_drop_allow", {31'd0, mem_allow_in}, 32'd0);
    check("f_drop_valid", {31'd0, mem_to_wb_valid}, 32'd0);
    step(); data_sram_data_ok = 1'b0;
    @(negedge clk); check("f_idle_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); ex_to_mem_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_AAAA;
    @(negedge clk); check("f_new_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    check("f_new_result", out_result, 32'hAAAA_AAAA);
    check("f_new_pc", out_pc, 32'h0000_1014);
    step(); data_sram_data_ok = 1'b0;

    // flush and response in the same cycle: no drop
    set_item(32'h0000_1018, 32'h0000_3008, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step(); ex_to_mem_valid = 1'b0; flush = 1'b1; data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    step(); flush = 1'b0; data_sram_data_ok = 1'b0;
    @(negedge clk); check("fs_allow", {31'd0, mem_allow_in}, 32'd1);
    check("fs_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // back-to-back word loads
    step();
    set_item(32'h0000_1020, 32'h0000_4000, 2'b10, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    set_item(32'h0000_1024, 32'h0000_4004, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("bb1_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    check("bb1_result", out_result, 32'hDEAD_BEEF);
    check("bb1_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); ex_to_mem_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk); check("bb2_valid", {31'd0, mem_to_wb_valid}, 32'd1);
    check("bb2_result", out_result, 32'h0BAD_F00D);
    check("bb2_pc", out_pc, 32'h0000_1024);
    step(); data_sram_data_ok = 1'b0;
    @(negedge clk); check("bb_after_valid", {31'd0, mem_to_wb_valid}, 32'd0);

    // reset while a response is outstanding
    step();
    set_item(32'h0000_1028, 32'h0000_5001, 2'b00, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    step(); ex_to_mem_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("r_pc", out_pc, 32'd0);
    check("r_result", out_result, 32'd0);
    check("r_misc", {24'd0, mem_to_wb_valid, out_gr_we, out_dest, fwd_block}, 32'd0);
    check("r_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    step(); step(); resetn = 1'b1;
    @(negedge clk); check("r_rel_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9999_9999;
    @(negedge clk); check("r_stray_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); data_sram_data_ok = 1'b0;
    set_item(32'h0000_102C, 32'h0000_0077, 2'b10, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    @(negedge clk); check("r_new_allow", {31'd0, mem_allow_in}, 32'd1);
    step(); ex_to_mem_valid = 1'b0;
    @(negedge clk); check("r_new_result", out_result, 32'h0000_0077);
    check("r_new_valid", {31'd0, mem_to_wb_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
